// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects and the result-source encoding that marks a load.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one execute-stage source register; the memory
// stage wins over writeback because it holds the younger result.
module forward_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REGISTER_WIDTH = 5
) (
  input  logic [REGISTER_WIDTH-1:0] rs_e,
  input  logic [REGISTER_WIDTH-1:0] rd_m,
  input  logic                      reg_write_m,
  input  logic [REGISTER_WIDTH-1:0] rd_w,
  input  logic                      reg_write_w,
  output fwd_sel_e                  sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use bubbles, control-flow
// flushes, data-memory wait handling with timeout, and stall/flush counters.
module hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REGISTER_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_ni,
  input  logic [REGISTER_WIDTH-1:0] rs1_d_i,
  input  logic [REGISTER_WIDTH-1:0] rs2_d_i,
  input  logic [REGISTER_WIDTH-1:0] rs1_e_i,
  input  logic [REGISTER_WIDTH-1:0] rs2_e_i,
  input  logic [REGISTER_WIDTH-1:0] rd_e_i,
  input  logic [1:0]                result_src_e_i,
  input  logic                      pc_src_e_i,
  input  logic [REGISTER_WIDTH-1:0] rd_m_i,
  input  logic                      reg_write_m_i,
  input  logic [REGISTER_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_w_i,
  input  logic                      mem_req_m_i,
  input  logic                      mem_ready_i,
  input  logic                      clr_cnt_i,
  output logic                      stall_f_o,
  output logic                      stall_d_o,
  output logic                      stall_e_o,
  output logic                      stall_m_o,
  output logic                      flush_d_o,
  output logic                      flush_e_o,
  output logic                      bubble_w_o,
  output logic [1:0]                forward_a_e_o,
  output logic [1:0]                forward_b_e_o,
  output logic                      mem_err_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_stall;
  logic                load_use;
  fwd_sel_e            fwd_a, fwd_b;

  forward_unit #(.REGISTER_WIDTH(REGISTER_WIDTH)) u_fwd_a (
    .rs_e        (rs1_e_i),
    .rd_m        (rd_m_i),
    .reg_write_m (reg_write_m_i),
    .rd_w        (rd_w_i),
    .reg_write_w (reg_write_w_i),
    .sel         (fwd_a)
  );

  forward_unit #(.REGISTER_WIDTH(REGISTER_WIDTH)) u_fwd_b (
    .rs_e        (rs2_e_i),
    .rd_m        (rd_m_i),
    .reg_write_m (reg_write_m_i),
    .rd_w        (rd_w_i),
    .reg_write_w (reg_write_w_i),
    .sel         (fwd_b)
  );

  assign forward_a_e_o = fwd_a;
  assign forward_b_e_o = fwd_b;

  assign load_use = (result_src_e_i == RESULT_SRC_MEM) && (rd_e_i != '0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A ready response in MEM_WAIT releases the stall in the same cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req_m_i && !mem_ready_i) begin
          mem_stall  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d = RUN;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ERROR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Memory stalls freeze everything, so a pending redirect waits rather than flushing.
  always_comb begin
    stall_f_o  = 1'b0;
    stall_d_o  = 1'b0;
    stall_e_o  = 1'b0;
    stall_m_o  = 1'b0;
    flush_d_o  = 1'b0;
    flush_e_o  = 1'b0;
    bubble_w_o = 1'b0;
    if (rst_ni) begin
      if (mem_stall) begin
        stall_f_o  = 1'b1;
        stall_d_o  = 1'b1;
        stall_e_o  = 1'b1;
        stall_m_o  = 1'b1;
        bubble_w_o = 1'b1;
      end else if (pc_src_e_i) begin
        flush_d_o = 1'b1;
        flush_e_o = 1'b1;
      end else if (load_use) begin
        stall_f_o = 1'b1;
        stall_d_o = 1'b1;
        flush_e_o = 1'b1;
      end
    end
  end

  assign mem_err_o = rst_ni && (state_q == ERROR);

  always_ff @(posedge clk) begin
    if (!rst_ni || clr_cnt_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_f_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
      end
      if (flush_d_o && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_controller;

  localparam int RW  = 5;
  localparam int TO  = 4;
  localparam int CW  = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [RW-1:0] rs1_d_i = '0, rs2_d_i = '0, rs1_e_i = '0, rs2_e_i = '0, rd_e_i = '0;
  logic [1:0]    result_src_e_i = '0;
  logic          pc_src_e_i = 1'b0;
  logic [RW-1:0] rd_m_i = '0, rd_w_i = '0;
  logic          reg_write_m_i = 1'b0, reg_write_w_i = 1'b0;
  logic          mem_req_m_i = 1'b0, mem_ready_i = 1'b0, clr_cnt_i = 1'b0;
  logic          stall_f_o, stall_d_o, stall_e_o, stall_m_o;
  logic          flush_d_o, flush_e_o, bubble_w_o, mem_err_o;
  logic [1:0]    forward_a_e_o, forward_b_e_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int num_checks = 0;
  int num_fails  = 0;

  hazard_controller #(.REGISTER_WIDTH(RW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i),
    .rs1_e_i(rs1_e_i), .rs2_e_i(rs2_e_i), .rd_e_i(rd_e_i),
    .result_src_e_i(result_src_e_i), .pc_src_e_i(pc_src_e_i),
    .rd_m_i(rd_m_i), .reg_write_m_i(reg_write_m_i),
    .rd_w_i(rd_w_i), .reg_write_w_i(reg_write_w_i),
    .mem_req_m_i(mem_req_m_i), .mem_ready_i(mem_ready_i), .clr_cnt_i(clr_cnt_i),
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o), .stall_m_o(stall_m_o),
    .flush_d_o(flush_d_o), .flush_e_o(flush_e_o), .bubble_w_o(bubble_w_o),
    .forward_a_e_o(forward_a_e_o), .forward_b_e_o(forward_b_e_o),
    .mem_err_o(mem_err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    rs1_d_i = '0; rs2_d_i = '0; rs1_e_i = '0; rs2_e_i = '0; rd_e_i = '0;
    result_src_e_i = '0; pc_src_e_i = 1'b0; rd_m_i = '0; rd_w_i = '0;
    reg_write_m_i = 1'b0; reg_write_w_i = 1'b0;
    mem_req_m_i = 1'b0; mem_ready_i = 1'b0; clr_cnt_i = 1'b0;
  endtask

  // Behavioural model: memory-wait bookkeeping as plain flags and integer counts.
  bit m_err = 0;
  bit m_waiting = 0;
  int m_waited = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  function automatic int fwd_of(input logic [RW-1:0] rs);
    if (reg_write_m_i && rd_m_i != 0 && rd_m_i == rs) return 2;
    if (reg_write_w_i && rd_w_i != 0 && rd_w_i == rs) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    bit lu, ms, e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_bw, e_err;
    lu = (result_src_e_i == 2'b01) && (rd_e_i != 0) &&
         (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i);
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_bw, e_err} = '0;
    if (rst_ni) begin
      ms = m_err || (m_waiting && !mem_ready_i) ||
           (!m_waiting && mem_req_m_i && !mem_ready_i);
      e_err = m_err;
      if (ms) begin
        {e_sf, e_sd, e_se, e_sm, e_bw} = 5'b11111;
      end else if (pc_src_e_i) begin
        {e_fd, e_fe} = 2'b11;
      end else if (lu) begin
        {e_sf, e_sd, e_fe} = 3'b111;
      end
    end
    checkOutput("model_forward_a", 32'(forward_a_e_o), 32'(fwd_of(rs1_e_i)));
    checkOutput("model_forward_b", 32'(forward_b_e_o), 32'(fwd_of(rs2_e_i)));
    checkOutput("model_stalls", 32'({stall_f_o, stall_d_o, stall_e_o, stall_m_o}),
                32'({e_sf, e_sd, e_se, e_sm}));
    checkOutput("model_flushes", 32'({flush_d_o, flush_e_o, bubble_w_o}), 32'({e_fd, e_fe, e_bw}));
    checkOutput("model_mem_err", 32'(mem_err_o), 32'(e_err));
    checkOutput("model_stall_cnt", 32'(stall_cnt_o), 32'(m_stalls));
    checkOutput("model_flush_cnt", 32'(flush_cnt_o), 32'(m_flushes));
    if (!rst_ni) begin
      m_err = 0; m_waiting = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (clr_cnt_i) begin
        m_stalls = 0; m_flushes = 0;
      end else begin
        if (e_sf && m_stalls < CNT_MAX) m_stalls++;
        if (e_fd && m_flushes < CNT_MAX) m_flushes++;
      end
      if (m_waiting) begin
        if (mem_ready_i) begin
          m_waiting = 0;
        end else begin
          m_waited++;
          if (m_waited == TO) begin
            m_waiting = 0;
            m_err = 1;
          end
        end
      end else if (!m_err && mem_req_m_i && !mem_ready_i) begin
        m_waiting = 1;
        m_waited = 0;
      end
    end
  end

  initial begin
    clearInputs();
    applyStimulus();
    applyStimulus();
    @(negedge clk);
    checkOutput("reset_stall_f", 32'(stall_f_o), 0);
    checkOutput("reset_stall_cnt", 32'(stall_cnt_o), 0);
    rst_ni = 1'b1;

    // Forwarding priority: memory stage beats writeback, x0 never forwards.
    applyStimulus();
    rd_m_i = 5; reg_write_m_i = 1; rd_w_i = 5; reg_write_w_i = 1; rs1_e_i = 5;
    @(negedge clk);
    checkOutput("fwd_a_mem", 32'(forward_a_e_o), 2);
    applyStimulus();
    rd_m_i = 0;
    @(negedge clk);
    checkOutput("fwd_a_wb", 32'(forward_a_e_o), 1);

    // Load-use bubble.
    applyStimulus();
    clearInputs();
    result_src_e_i = 2'b01; rd_e_i = 7; rs2_d_i = 7;
    @(negedge clk);
    checkOutput("lu_stalls", 32'({stall_f_o, stall_d_o, stall_e_o, stall_m_o}), 32'b1100);
    checkOutput("lu_flush_e", 32'(flush_e_o), 1);
    applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("lu_stall_cnt", 32'(stall_cnt_o), 1);

    // Memory wait with a branch pending: flush deferred until ready.
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      mem_req_m_i = 1; mem_ready_i = 0; pc_src_e_i = 1;
      @(negedge clk);
      checkOutput("mw_stall_bubble", 32'({stall_f_o, stall_m_o, bubble_w_o, flush_d_o}), 32'b1110);
    end
    applyStimulus();
    mem_ready_i = 1;
    @(negedge clk);
    checkOutput("mw_release_flush", 32'({flush_d_o, flush_e_o, stall_f_o}), 32'b110);
    applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("mw_back_in_run", 32'(stall_f_o), 0);
    checkOutput("mw_stall_cnt", 32'(stall_cnt_o), 4);
    checkOutput("mw_flush_cnt", 32'(flush_cnt_o), 1);

    // Clear coincident with a flush.
    applyStimulus();
    pc_src_e_i = 1;
    @(negedge clk);
    checkOutput("clr_pre", 32'(flush_cnt_o), 1);
    applyStimulus();
    clr_cnt_i = 1;
    @(negedge clk);
    checkOutput("clr_same", 32'(flush_cnt_o), 2);
    applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("clr_flush_cnt", 32'(flush_cnt_o), 0);
    checkOutput("clr_stall_cnt", 32'(stall_cnt_o), 0);

    // Timeout: error appears the cycle after the fourth MEM_WAIT cycle.
    applyStimulus();
    mem_req_m_i = 1; mem_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("to_not_yet", 32'(mem_err_o), 0);
    end
    @(negedge clk);
    checkOutput("to_error", 32'(mem_err_o), 1);
    applyStimulus();
    mem_req_m_i = 0; mem_ready_i = 1;
    @(negedge clk);
    checkOutput("to_absorbing", 32'({mem_err_o, stall_f_o}), 32'b11);
    applyStimulus();
    rst_ni = 0;
    @(negedge clk);
    checkOutput("to_reset_outputs", 32'({mem_err_o, stall_f_o, bubble_w_o}), 0);
    applyStimulus();
    rst_ni = 1; mem_ready_i = 0;
    @(negedge clk);
    checkOutput("to_run_after_reset", 32'({mem_err_o, stall_f_o}), 0);
    checkOutput("to_cnt_cleared", 32'(stall_cnt_o), 0);

    // Stall counter saturation.
    applyStimulus();
    clearInputs();
    result_src_e_i = 2'b01; rd_e_i = 3; rs1_d_i = 3;
    repeat (CNT_MAX + 6) applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("sat_stall_cnt", 32'(stall_cnt_o), 32'(CNT_MAX));

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      rst_ni         = ($urandom_range(0, 99) != 0);
      clr_cnt_i      = ($urandom_range(0, 49) == 0);
      rs1_d_i        = RW'($urandom_range(0, 3));
      rs2_d_i        = RW'($urandom_range(0, 3));
      rs1_e_i        = RW'($urandom_range(0, 3));
      rs2_e_i        = RW'($urandom_range(0, 3));
      rd_e_i         = RW'($urandom_range(0, 3));
      rd_m_i         = RW'($urandom_range(0, 3));
      rd_w_i         = RW'($urandom_range(0, 3));
      reg_write_m_i  = 1'($urandom_range(0, 1));
      reg_write_w_i  = 1'($urandom_range(0, 1));
      result_src_e_i = 2'($urandom_range(0, 3));
      pc_src_e_i     = ($urandom_range(0, 4) == 0);
      mem_req_m_i    = ($urandom_range(0, 9) < 3);
      mem_ready_i    = ($urandom_range(0, 9) < 4);
    end
    applyStimulus();
    clearInputs();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
